// File: rtl/reorder_buffer.sv
// reorder_buffer: 2^ROB_WIDTH-entry in-order retirement buffer fed by the CDB, with mispredict flush.
// Latency: writeback -> commit at the following edge at the earliest; commit/flush outputs are registered.
// Backpressure: full blocks issue (judged on pre-edge count); rdy_in low freezes all state and outputs.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global stall)
//   issue_valid/issue_rd -> issue_tag, full         : allocate at tail
//   wb_valid/wb_tag/wb_val/wb_mispredict/wb_target  : CDB writeback
//   commit_valid/commit_reg/commit_val/commit_tag   : retire to register file
//   flush/flush_pc                                  : redirect on mispredicted commit
//   query_tag_n -> query_ready_n/query_val_n         : operand lookup (n = 1,2)
// Optional feature: define ROB_BYPASS_EN to forward a same-cycle CDB result to the query ports.
// Register file hookup: set_reg = commit_valid ? commit_reg : 0, set_val = commit_val.

module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 full,
    input  logic                 wb_valid,
    input  logic [ROB_WIDTH-1:0] wb_tag,
    input  logic [31:0]          wb_val,
    input  logic                 wb_mispredict,
    input  logic [31:0]          wb_target,
    output logic                 commit_valid,
    output logic [4:0]           commit_reg,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    output logic                 query_ready_1,
    output logic [31:0]          query_val_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_2,
    output logic [31:0]          query_val_2
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0]   DEPTH_CNT = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [ROB_WIDTH:0]   CNT_ONE   = (ROB_WIDTH+1)'(1);
    localparam logic [ROB_WIDTH-1:0] PTR_ONE   = ROB_WIDTH'(1);

    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     ready;
    logic [DEPTH-1:0]     mispred;
    logic [4:0]           rd_q     [DEPTH];
    logic [31:0]          val_q    [DEPTH];
    logic [31:0]          target_q [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    logic do_issue;
    logic do_wb;
    logic do_commit;
    logic do_flush;

    assign issue_tag = tail;
    assign full      = (count == DEPTH_CNT);

    // All decisions use pre-edge state: a slot freed by this edge's commit is
    // not reusable until the next edge, and a result written back this edge
    // cannot retire until the next edge.
    assign do_issue  = issue_valid && !full;
    assign do_wb     = wb_valid && busy[wb_tag];
    assign do_commit = busy[head] && ready[head];
    assign do_flush  = do_commit && mispred[head];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            commit_valid <= 1'b0;
            commit_reg   <= '0;
            commit_val   <= '0;
            commit_tag   <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else if (rdy_in) begin
            commit_valid <= do_commit;
            flush        <= do_flush;
            if (do_commit) begin
                commit_reg <= rd_q[head];
                commit_val <= val_q[head];
                commit_tag <= head;
            end
            if (do_flush) begin
                // Everything younger than the mispredicted entry is wrong-path;
                // same-edge issue and writeback are dropped with it.
                flush_pc <= target_q[head];
                busy     <= '0;
                ready    <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (do_wb) begin
                    ready[wb_tag]    <= 1'b1;
                    val_q[wb_tag]    <= wb_val;
                    mispred[wb_tag]  <= wb_mispredict;
                    target_q[wb_tag] <= wb_target;
                end
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + PTR_ONE;
                end
                // tail != head whenever an issue is accepted (not full), so
                // this never collides with the commit clear above.
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    rd_q[tail]  <= issue_rd;
                    tail        <= tail + PTR_ONE;
                end
                case ({do_issue, do_commit})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    always_comb begin
        query_ready_1 = busy[query_tag_1] && ready[query_tag_1];
        query_val_1   = val_q[query_tag_1];
        query_ready_2 = busy[query_tag_2] && ready[query_tag_2];
        query_val_2   = val_q[query_tag_2];
`ifdef ROB_BYPASS_EN
        if (wb_valid && (wb_tag == query_tag_1) && busy[query_tag_1]) begin
            query_ready_1 = 1'b1;
            query_val_1   = wb_val;
        end
        if (wb_valid && (wb_tag == query_tag_2) && busy[query_tag_2]) begin
            query_ready_2 = 1'b1;
            query_val_2   = wb_val;
        end
`else
        // Stored entry state only: a same-cycle CDB result is visible next cycle.
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios for reorder_buffer with a commit scoreboard.
// Expected commits are queued at issue time; writeback values are recorded in a model array.
// Inputs are driven and outputs sampled 1ns after each rising edge.

module tb_reorder_buffer;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        full;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_val;
    logic        wb_mispredict;
    logic [31:0] wb_target;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [31:0] commit_val;
    logic [3:0]  commit_tag;
    logic        flush;
    logic [31:0] flush_pc;
    logic [3:0]  query_tag_1;
    logic        query_ready_1;
    logic [31:0] query_val_1;
    logic [3:0]  query_tag_2;
    logic        query_ready_2;
    logic [31:0] query_val_2;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_tag(issue_tag), .full(full),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .commit_valid(commit_valid), .commit_reg(commit_reg),
        .commit_val(commit_val), .commit_tag(commit_tag),
        .flush(flush), .flush_pc(flush_pc),
        .query_tag_1(query_tag_1), .query_ready_1(query_ready_1), .query_val_1(query_val_1),
        .query_tag_2(query_tag_2), .query_ready_2(query_ready_2), .query_val_2(query_val_2)
    );

`ifdef ROB_BYPASS_EN
    localparam logic EXP_BYP = 1'b1;
`else
    localparam logic EXP_BYP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] tag;
        logic [4:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl_val [16];
    logic [3:0]  mdl_tail;
    int          errors = 0;
    int          checks = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_val = '0; wb_mispredict = 1'b0; wb_target = '0;
        query_tag_1 = '0; query_tag_2 = '0;
        cyc(); cyc();
        rst_in = 1'b0;
        exp_q.delete();
        mdl_tail = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        exp_t e;
        issue_valid = 1'b1; issue_rd = rd;
        e.tag = mdl_tail; e.rd = rd;
        exp_q.push_back(e);
        mdl_tail = mdl_tail + 4'd1;
        cyc();
        issue_valid = 1'b0;
    endtask

    task automatic wb(input logic [3:0] tag, input logic [31:0] val,
                      input logic mis, input logic [31:0] tgt);
        wb_valid = 1'b1; wb_tag = tag; wb_val = val; wb_mispredict = mis; wb_target = tgt;
        mdl_val[tag] = val;
        cyc();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid: got %0h want 0", commit_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0h want 0", flush); end
        checks++; if ({commit_reg, commit_val, commit_tag, flush_pc} !== '0) begin errors++;
            $display("FAIL reset_outputs: reg=%0h val=%0h tag=%0h pc=%0h want 0", commit_reg, commit_val, commit_tag, flush_pc); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h want 0", full); end
        checks++; if (issue_tag !== 4'd0) begin errors++; $display("FAIL reset_issue_tag: got %0h want 0", issue_tag); end
    endtask

    task automatic test_basic_commit();
        exp_t e;
        do_reset();
        issue(5'd5);
        wb(4'd0, 32'h1234, 1'b0, 32'h0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL basic_no_same_edge_commit: got %0h want 0", commit_valid); end
        query_tag_1 = 4'd0; #1;
        checks++; if (query_ready_1 !== 1'b1 || query_val_1 !== 32'h1234) begin errors++;
            $display("FAIL basic_query: ready=%0h val=%0h want 1/1234", query_ready_1, query_val_1); end
        cyc();
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL basic_commit_valid: got %0h want 1", commit_valid); end
        if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL basic_scoreboard: got empty queue want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (commit_tag !== e.tag || commit_reg !== e.rd || commit_val !== mdl_val[e.tag]) begin errors++;
                $display("FAIL basic_commit_data: got tag=%0h reg=%0h val=%0h want tag=%0h reg=%0h val=%0h",
                         commit_tag, commit_reg, commit_val, e.tag, e.rd, mdl_val[e.tag]); end
        end
        cyc();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL basic_commit_drop: got %0h want 0", commit_valid); end
    endtask

    task automatic test_full();
        exp_t e;
        do_reset();
        for (int i = 0; i < 16; i++) issue(5'(i));
        checks++; if (full !== 1'b1 || issue_tag !== 4'd0) begin errors++;
            $display("FAIL full_after_16: full=%0h tag=%0h want 1/0", full, issue_tag); end
        issue_valid = 1'b1; issue_rd = 5'd31;
        cyc();
        issue_valid = 1'b0;
        checks++; if (full !== 1'b1 || issue_tag !== 4'd0) begin errors++;
            $display("FAIL full_17th_ignored: full=%0h tag=%0h want 1/0", full, issue_tag); end
        wb(4'd0, 32'hA0, 1'b0, 32'h0);
        // Issue coincides with the first commit while still full pre-edge: must be ignored.
        issue_valid = 1'b1; issue_rd = 5'd30;
        cyc();
        issue_valid = 1'b0;
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL full_commit_valid: got %0h want 1", commit_valid); end
        if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL full_scoreboard: got empty queue want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (commit_tag !== e.tag || commit_reg !== e.rd || commit_val !== mdl_val[e.tag]) begin errors++;
                $display("FAIL full_commit_data: got tag=%0h reg=%0h val=%0h want tag=%0h reg=%0h val=%0h",
                         commit_tag, commit_reg, commit_val, e.tag, e.rd, mdl_val[e.tag]); end
        end
        checks++; if (full !== 1'b0 || issue_tag !== 4'd0) begin errors++;
            $display("FAIL full_after_commit: full=%0h tag=%0h want 0/0", full, issue_tag); end
        issue(5'd30);
        checks++; if (full !== 1'b1 || issue_tag !== 4'd1) begin errors++;
            $display("FAIL full_refill: full=%0h tag=%0h want 1/1", full, issue_tag); end
    endtask

    task automatic test_out_of_order();
        exp_t e;
        do_reset();
        issue(5'd7);
        issue(5'd9);
        wb(4'd1, 32'h11, 1'b0, 32'h0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_young_held: got %0h want 0", commit_valid); end
        wb(4'd0, 32'h22, 1'b0, 32'h0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_same_edge: got %0h want 0", commit_valid); end
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL ooo_commit_valid_%0d: got %0h want 1", k, commit_valid); end
            if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL ooo_scoreboard_%0d: got empty queue want entry", k); end
            else begin
                e = exp_q.pop_front();
                checks++; if (commit_tag !== e.tag || commit_reg !== e.rd || commit_val !== mdl_val[e.tag]) begin errors++;
                    $display("FAIL ooo_commit_data_%0d: got tag=%0h reg=%0h val=%0h want tag=%0h reg=%0h val=%0h",
                             k, commit_tag, commit_reg, commit_val, e.tag, e.rd, mdl_val[e.tag]); end
            end
        end
        cyc();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained: got %0h want 0", commit_valid); end
    endtask

    task automatic test_mispredict();
        exp_t e;
        do_reset();
        issue(5'd1); issue(5'd2); issue(5'd3);
        wb(4'd0, 32'hDEAD, 1'b1, 32'h100);
        // Issue and writeback on the flushing edge must both be dropped.
        issue_valid = 1'b1; issue_rd = 5'd4;
        wb_valid = 1'b1; wb_tag = 4'd1; wb_val = 32'h99;
        cyc();
        issue_valid = 1'b0; wb_valid = 1'b0;
        checks++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin errors++;
            $display("FAIL mis_flush: flush=%0h pc=%0h want 1/100", flush, flush_pc); end
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL mis_commit_valid: got %0h want 1", commit_valid); end
        if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL mis_scoreboard: got empty queue want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (commit_tag !== e.tag || commit_reg !== e.rd || commit_val !== mdl_val[e.tag]) begin errors++;
                $display("FAIL mis_commit_data: got tag=%0h reg=%0h val=%0h want tag=%0h reg=%0h val=%0h",
                         commit_tag, commit_reg, commit_val, e.tag, e.rd, mdl_val[e.tag]); end
        end
        query_tag_1 = 4'd1; #1;
        checks++; if (issue_tag !== 4'd0 || full !== 1'b0 || query_ready_1 !== 1'b0) begin errors++;
            $display("FAIL mis_state_cleared: tag=%0h full=%0h qrdy=%0h want 0/0/0", issue_tag, full, query_ready_1); end
        cyc();
        checks++; if (flush !== 1'b0 || commit_valid !== 1'b0) begin errors++;
            $display("FAIL mis_pulse_end: flush=%0h commit=%0h want 0/0", flush, commit_valid); end
    endtask

    task automatic test_bypass();
        do_reset();
        issue(5'd1); issue(5'd2); issue(5'd3);
        query_tag_1 = 4'd2; query_tag_2 = 4'd1;
        wb_valid = 1'b1; wb_tag = 4'd2; wb_val = 32'h55; mdl_val[2] = 32'h55;
        #1;
        checks++; if (query_ready_1 !== EXP_BYP) begin errors++;
            $display("FAIL byp_same_cycle_ready: got %0h want %0h", query_ready_1, EXP_BYP); end
`ifdef ROB_BYPASS_EN
        checks++; if (query_val_1 !== 32'h55) begin errors++; $display("FAIL byp_same_cycle_val: got %0h want 55", query_val_1); end
`endif
        checks++; if (query_ready_2 !== 1'b0) begin errors++; $display("FAIL byp_other_tag: got %0h want 0", query_ready_2); end
        cyc();
        wb_valid = 1'b0;
        checks++; if (query_ready_1 !== 1'b1 || query_val_1 !== mdl_val[2]) begin errors++;
            $display("FAIL byp_stored: ready=%0h val=%0h want 1/%0h", query_ready_1, query_val_1, mdl_val[2]); end
        query_tag_2 = 4'd9; wb_valid = 1'b1; wb_tag = 4'd9; wb_val = 32'h66;
        #1;
        checks++; if (query_ready_2 !== 1'b0) begin errors++; $display("FAIL byp_not_busy: got %0h want 0", query_ready_2); end
        wb_valid = 1'b0;
    endtask

    task automatic test_stall_and_reset();
        exp_t e;
        do_reset();
        issue(5'd4);
        wb(4'd0, 32'h77, 1'b0, 32'h0);
        rdy_in = 1'b0; issue_valid = 1'b1; issue_rd = 5'd6;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (commit_valid !== 1'b0 || issue_tag !== 4'd1) begin errors++;
                $display("FAIL stall_frozen_%0d: commit=%0h tag=%0h want 0/1", k, commit_valid, issue_tag); end
        end
        issue_valid = 1'b0; rdy_in = 1'b1;
        cyc();
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL stall_release_commit: got %0h want 1", commit_valid); end
        if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL stall_scoreboard: got empty queue want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (commit_tag !== e.tag || commit_reg !== e.rd || commit_val !== mdl_val[e.tag]) begin errors++;
                $display("FAIL stall_commit_data: got tag=%0h reg=%0h val=%0h want tag=%0h reg=%0h val=%0h",
                         commit_tag, commit_reg, commit_val, e.tag, e.rd, mdl_val[e.tag]); end
        end
        rdy_in = 1'b0;
        cyc(); cyc();
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd0) begin errors++;
            $display("FAIL stall_pulse_held: commit=%0h tag=%0h want 1/0", commit_valid, commit_tag); end
        rdy_in = 1'b1;
        cyc();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse_end: got %0h want 0", commit_valid); end
        issue(5'd10); issue(5'd11);
        wb(4'd1, 32'hAA, 1'b0, 32'h0);
        wb(4'd2, 32'hBB, 1'b0, 32'h0);
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd1 || commit_reg !== 5'd10 || commit_val !== 32'hAA) begin errors++;
            $display("FAIL midstream_commit: v=%0h tag=%0h reg=%0h val=%0h want 1/1/a/aa", commit_valid, commit_tag, commit_reg, commit_val); end
        // Reset lands with an issue, a writeback and a pending commit in flight, and rdy_in low.
        rst_in = 1'b1; rdy_in = 1'b0; issue_valid = 1'b1; issue_rd = 5'd12;
        wb_valid = 1'b1; wb_tag = 4'd2; wb_val = 32'hCC;
        cyc();
        rst_in = 1'b0; rdy_in = 1'b1; issue_valid = 1'b0; wb_valid = 1'b0;
        exp_q.delete();
        query_tag_1 = 4'd2; #1;
        checks++; if ({commit_valid, commit_reg, commit_val, commit_tag, flush, flush_pc} !== '0) begin errors++;
            $display("FAIL midreset_outputs: v=%0h reg=%0h val=%0h tag=%0h fl=%0h pc=%0h want 0",
                     commit_valid, commit_reg, commit_val, commit_tag, flush, flush_pc); end
        checks++; if (issue_tag !== 4'd0 || full !== 1'b0 || query_ready_1 !== 1'b0) begin errors++;
            $display("FAIL midreset_state: tag=%0h full=%0h qrdy=%0h want 0/0/0", issue_tag, full, query_ready_1); end
        cyc();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_commit: got %0h want 0", commit_valid); end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; issue_valid = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_val = '0; wb_mispredict = 1'b0; wb_target = '0;
        query_tag_1 = '0; query_tag_2 = '0; mdl_tail = '0;
        for (int i = 0; i < 16; i++) mdl_val[i] = '0;
        test_reset();
        test_basic_commit();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_bypass();
        test_stall_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
